// File: rtl/ahb_req_arbiter.sv
// Round-robin arbiter + burst sequencer in front of one AHB-Lite master.
// Ports: req_* (per-requester commands), m_* (master application side).
module ahb_req_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int LEN_W   = 4
) (
  input  logic                     HCLK,
  input  logic                     HRESETn,
  input  logic [NUM_REQ-1:0]       req_valid,
  input  logic [NUM_REQ*32-1:0]    req_addr,
  input  logic [NUM_REQ-1:0]       req_wr,
  input  logic [NUM_REQ*LEN_W-1:0] req_len,
  input  logic [NUM_REQ*32-1:0]    req_wdata,
  output logic [NUM_REQ-1:0]       req_ready,
  output logic [NUM_REQ-1:0]       wdata_ack,
  output logic [31:0]              rdata,
  output logic [NUM_REQ-1:0]       rdata_valid,
  output logic [NUM_REQ-1:0]       done,
  output logic                     busy,
  output logic                     m_enable,
  output logic                     m_new_trans,
  output logic                     m_inc,
  output logic                     m_wr,
  output logic [31:0]              m_addr,
  output logic [31:0]              m_data_in,
  input  logic [31:0]              m_data_out,
  input  logic                     m_data_valid,
  input  logic                     m_wait
);

  localparam int GW = $clog2(NUM_REQ);

  typedef enum logic [1:0] {
    IDLE,
    BURST,
    LAST
  } state_t;

  state_t state, state_n;

  logic [GW-1:0]    g;
  logic [GW-1:0]    last_grant;
  logic [GW-1:0]    pick_idx;
  logic             pick_hit;
  logic [31:0]      cur_addr;
  logic             wr_q;
  logic [LEN_W-1:0] len_q;
  logic [LEN_W:0]   beat;
  logic             go;
  logic             last_beat;
  logic             data_ph;

  logic [31:0]      addr_a  [NUM_REQ];
  logic [31:0]      wdata_a [NUM_REQ];
  logic [LEN_W-1:0] len_a   [NUM_REQ];

  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      addr_a[i]  = req_addr[i*32 +: 32];
      wdata_a[i] = req_wdata[i*32 +: 32];
      len_a[i]   = req_len[i*LEN_W +: LEN_W];
    end
  end

  // Search upward from last_grant+1, wrapping.
  always_comb begin : arb
    int k;
    logic [GW-1:0] kk;
    k        = 0;
    kk       = '0;
    pick_hit = 1'b0;
    pick_idx = '0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      k  = (int'(last_grant) + i) % NUM_REQ;
      kk = GW'(k);
      if (!pick_hit && req_valid[kk]) begin
        pick_hit = 1'b1;
        pick_idx = kk;
      end
    end
  end

  assign go        = !m_wait;
  assign last_beat = (beat == {1'b0, len_q});
  // A data phase is pending once the first address beat was accepted.
  assign data_ph   = (state == BURST && beat != '0)
                   || (state == LAST);

  always_comb begin
    state_n     = state;
    req_ready   = '0;
    wdata_ack   = '0;
    rdata       = '0;
    rdata_valid = '0;
    done        = '0;
    busy        = (state != IDLE);
    m_enable    = 1'b0;
    m_new_trans = 1'b0;
    m_inc       = 1'b0;
    m_wr        = 1'b0;
    m_addr      = '0;
    m_data_in   = '0;
    unique case (state)
      IDLE: begin
        // No grant while in reset, or the command would be lost.
        if (pick_hit && go && HRESETn) begin
          req_ready[pick_idx] = 1'b1;
          state_n             = BURST;
        end
      end
      BURST: begin
        m_enable    = 1'b1;
        m_addr      = cur_addr;
        m_wr        = wr_q;
        // Restart as NONSEQ at each 1 KB boundary.
        m_new_trans = (beat == '0)
                    || (cur_addr[9:0] == 10'd0);
        m_inc       = !last_beat;
        if (go && last_beat) state_n = LAST;
      end
      LAST: begin
        m_enable = 1'b1;
        m_addr   = cur_addr;
        m_wr     = wr_q;
        if (go) begin
          done[g] = 1'b1;
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
    // Write data is held through wait states.
    if (data_ph) begin
      if (wr_q) begin
        m_data_in    = wdata_a[g];
        wdata_ack[g] = go;
      end else begin
        rdata          = m_data_out;
        rdata_valid[g] = go & m_data_valid;
      end
    end
  end

  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      state      <= IDLE;
      g          <= '0;
      last_grant <= GW'(NUM_REQ - 1);
      cur_addr   <= '0;
      wr_q       <= 1'b0;
      len_q      <= '0;
      beat       <= '0;
    end else begin
      state <= state_n;
      if (state == IDLE && state_n == BURST) begin
        g          <= pick_idx;
        last_grant <= pick_idx;
        cur_addr   <= addr_a[pick_idx] & ~32'h3;
        wr_q       <= req_wr[pick_idx];
        len_q      <= len_a[pick_idx];
        beat       <= '0;
      end else if (state == BURST && go) begin
        cur_addr <= cur_addr + 32'd4;
        beat     <= beat + (LEN_W+1)'(1);
      end
    end
  end

endmodule

// File: tb/tb_ahb_req_arbiter.sv
// Directed self-checking bench for ahb_req_arbiter.
// One task per scenario, inline comparisons.
module tb_ahb_req_arbiter;

  localparam int N  = 4;
  localparam int LW = 4;

  logic            HCLK = 1'b0;
  logic            HRESETn;
  logic [N-1:0]    req_valid;
  logic [N*32-1:0] req_addr;
  logic [N-1:0]    req_wr;
  logic [N*LW-1:0] req_len;
  logic [N*32-1:0] req_wdata;
  logic [N-1:0]    req_ready;
  logic [N-1:0]    wdata_ack;
  logic [31:0]     rdata;
  logic [N-1:0]    rdata_valid;
  logic [N-1:0]    done;
  logic            busy;
  logic            m_enable;
  logic            m_new_trans;
  logic            m_inc;
  logic            m_wr;
  logic [31:0]     m_addr;
  logic [31:0]     m_data_in;
  logic [31:0]     m_data_out;
  logic            m_data_valid;
  logic            m_wait;

  int checks = 0;
  int errors = 0;

  ahb_req_arbiter #(.NUM_REQ(N), .LEN_W(LW)) dut (
    .HCLK        (HCLK),
    .HRESETn     (HRESETn),
    .req_valid   (req_valid),
    .req_addr    (req_addr),
    .req_wr      (req_wr),
    .req_len     (req_len),
    .req_wdata   (req_wdata),
    .req_ready   (req_ready),
    .wdata_ack   (wdata_ack),
    .rdata       (rdata),
    .rdata_valid (rdata_valid),
    .done        (done),
    .busy        (busy),
    .m_enable    (m_enable),
    .m_new_trans (m_new_trans),
    .m_inc       (m_inc),
    .m_wr        (m_wr),
    .m_addr      (m_addr),
    .m_data_in   (m_data_in),
    .m_data_out  (m_data_out),
    .m_data_valid(m_data_valid),
    .m_wait      (m_wait)
  );

  always #5 HCLK = ~HCLK;

  task automatic tick();
    @(posedge HCLK);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic set_req(input int i, input logic [31:0] a,
                         input logic w, input logic [3:0] l);
    req_addr[i*32 +: 32] = a;
    req_wr[i]            = w;
    req_len[i*LW +: LW]  = l;
  endtask

  task automatic test_reset();
    HRESETn      = 1'b0;
    req_valid    = '0;
    req_addr     = '0;
    req_wr       = '0;
    req_len      = '0;
    req_wdata    = '0;
    m_data_out   = '0;
    m_data_valid = 1'b0;
    m_wait       = 1'b0;
    tick();
    tick();
    HRESETn = 1'b1;
    settle();
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_busy: got %0b want 0", busy);
    end
    checks++;
    if (m_enable !== 1'b0 || m_addr !== 32'd0) begin
      errors++;
      $display("FAIL reset_master: en %0b addr %h want 0/0",
               m_enable, m_addr);
    end
    checks++;
    if (req_ready !== 4'd0 || done !== 4'd0) begin
      errors++;
      $display("FAIL reset_pulses: ready %b done %b want 0/0",
               req_ready, done);
    end
    tick();
  endtask

  task automatic test_single_read();
    int pulses;
    logic [3:0] exp_rv;
    logic [3:0] exp_done;
    logic [31:0] exp_a;
    pulses       = 0;
    m_data_valid = 1'b1;
    set_req(0, 32'h100, 1'b0, 4'd3);
    req_valid = 4'b0001;
    settle();
    checks++;
    if (req_ready !== 4'b0001) begin
      errors++;
      $display("FAIL rd_grant: got %b want 0001", req_ready);
    end
    tick();
    req_valid = '0;
    for (int k = 1; k <= 6; k++) begin
      m_data_out = 32'hA000_0000 + 32'(k);
      settle();
      exp_rv   = (k >= 2 && k <= 5) ? 4'b0001 : 4'b0000;
      exp_done = (k == 5) ? 4'b0001 : 4'b0000;
      checks++;
      if (rdata_valid !== exp_rv) begin
        errors++;
        $display("FAIL rd_rvalid c%0d: got %b want %b",
                 k, rdata_valid, exp_rv);
      end
      if (exp_rv != 4'b0000) begin
        checks++;
        if (rdata !== 32'hA000_0000 + 32'(k)) begin
          errors++;
          $display("FAIL rd_data c%0d: got %h want %h",
                   k, rdata, 32'hA000_0000 + 32'(k));
        end
      end
      checks++;
      if (done !== exp_done) begin
        errors++;
        $display("FAIL rd_done c%0d: got %b want %b",
                 k, done, exp_done);
      end
      checks++;
      if (m_enable !== (k <= 5)) begin
        errors++;
        $display("FAIL rd_en c%0d: got %0b want %0b",
                 k, m_enable, (k <= 5));
      end
      if (k <= 4) begin
        exp_a = 32'h100 + 32'(4 * (k - 1));
        checks++;
        if (m_addr !== exp_a || m_new_trans !== (k == 1)
            || m_inc !== (k != 4) || m_wr !== 1'b0) begin
          errors++;
          $display("FAIL rd_beat c%0d: a %h nt %0b inc %0b wr %0b want a %h nt %0b inc %0b wr 0",
                   k, m_addr, m_new_trans, m_inc, m_wr,
                   exp_a, (k == 1), (k != 4));
        end
      end
      if (rdata_valid[0]) pulses++;
      tick();
    end
    checks++;
    if (pulses != 4) begin
      errors++;
      $display("FAIL rd_count: got %0d want 4", pulses);
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL rd_idle: busy %0b want 0", busy);
    end
  endtask

  task automatic test_single_write();
    set_req(1, 32'h21, 1'b1, 4'd0);
    req_wdata[32 +: 32] = 32'hDEAD_BEEF;
    req_valid = 4'b0010;
    settle();
    checks++;
    if (req_ready !== 4'b0010) begin
      errors++;
      $display("FAIL wr_grant: got %b want 0010", req_ready);
    end
    tick();
    req_valid = '0;
    settle();
    checks++;
    if (m_addr !== 32'h20 || m_inc !== 1'b0
        || m_new_trans !== 1'b1 || m_wr !== 1'b1) begin
      errors++;
      $display("FAIL wr_addr: a %h inc %0b nt %0b wr %0b want 20/0/1/1",
               m_addr, m_inc, m_new_trans, m_wr);
    end
    checks++;
    if (wdata_ack !== 4'd0) begin
      errors++;
      $display("FAIL wr_early_ack: got %b want 0000", wdata_ack);
    end
    tick();
    checks++;
    if (wdata_ack !== 4'b0010 || m_data_in !== 32'hDEAD_BEEF) begin
      errors++;
      $display("FAIL wr_data: ack %b din %h want 0010/deadbeef",
               wdata_ack, m_data_in);
    end
    checks++;
    if (done !== 4'b0010) begin
      errors++;
      $display("FAIL wr_done: got %b want 0010", done);
    end
    tick();
    checks++;
    if (busy !== 1'b0 || done !== 4'd0) begin
      errors++;
      $display("FAIL wr_idle: busy %0b done %b want 0/0000",
               busy, done);
    end
  endtask

  task automatic test_round_robin();
    int got;
    logic [3:0] exp;
    logic seen;
    HRESETn = 1'b0;
    tick();
    HRESETn = 1'b1;
    for (int i = 0; i < 3; i++) set_req(i, 32'h40, 1'b0, 4'd0);
    req_valid = 4'b0111;
    got = 0;
    for (int c = 0; c < 60 && got < 6; c++) begin
      settle();
      if (req_ready != 4'd0) begin
        exp = 4'b0001 << (got % 3);
        checks++;
        if (req_ready !== exp) begin
          errors++;
          $display("FAIL rr_grant%0d: got %b want %b",
                   got, req_ready, exp);
        end
        got++;
      end
      tick();
    end
    checks++;
    if (got != 6) begin
      errors++;
      $display("FAIL rr_timeout: grants %0d want 6", got);
    end
    set_req(3, 32'h80, 1'b0, 4'd0);
    req_valid = 4'b1000;
    seen = 1'b0;
    for (int c = 0; c < 20 && !seen; c++) begin
      settle();
      if (req_ready != 4'd0) begin
        seen = 1'b1;
        checks++;
        if (req_ready !== 4'b1000) begin
          errors++;
          $display("FAIL rr_lone3: got %b want 1000", req_ready);
        end
      end
      tick();
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL rr_lone3_timeout: no grant want 1000");
    end
    req_valid = '0;
    for (int c = 0; c < 4; c++) tick();
  endtask

  task automatic test_wait();
    logic [31:0] exp_a;
    logic [3:0] exp_rv;
    int pulses;
    pulses = 0;
    set_req(0, 32'h100, 1'b0, 4'd3);
    req_valid = 4'b0001;
    settle();
    checks++;
    if (req_ready !== 4'b0001) begin
      errors++;
      $display("FAIL wt_grant: got %b want 0001", req_ready);
    end
    tick();
    req_valid = '0;
    for (int k = 1; k <= 8; k++) begin
      m_wait = (k == 3 || k == 4);
      settle();
      case (k)
        1:       exp_a = 32'h100;
        2:       exp_a = 32'h104;
        6:       exp_a = 32'h10C;
        default: exp_a = 32'h108;
      endcase
      exp_rv = (k == 2 || k == 5 || k == 6 || k == 7)
               ? 4'b0001 : 4'b0000;
      if (k <= 6) begin
        checks++;
        if (m_addr !== exp_a) begin
          errors++;
          $display("FAIL wt_addr c%0d: got %h want %h",
                   k, m_addr, exp_a);
        end
      end
      checks++;
      if (rdata_valid !== exp_rv) begin
        errors++;
        $display("FAIL wt_rvalid c%0d: got %b want %b",
                 k, rdata_valid, exp_rv);
      end
      checks++;
      if (done !== ((k == 7) ? 4'b0001 : 4'b0000)) begin
        errors++;
        $display("FAIL wt_done c%0d: got %b want %b",
                 k, done, (k == 7) ? 4'b0001 : 4'b0000);
      end
      if (rdata_valid[0]) pulses++;
      tick();
    end
    m_wait = 1'b0;
    checks++;
    if (pulses != 4 || busy !== 1'b0) begin
      errors++;
      $display("FAIL wt_total: pulses %0d busy %0b want 4/0",
               pulses, busy);
    end
  endtask

  task automatic test_boundary();
    logic [31:0] exp_a;
    set_req(1, 32'h3F8, 1'b0, 4'd3);
    req_valid = 4'b0010;
    settle();
    checks++;
    if (req_ready !== 4'b0010) begin
      errors++;
      $display("FAIL kb_grant: got %b want 0010", req_ready);
    end
    tick();
    req_valid = '0;
    for (int k = 1; k <= 6; k++) begin
      settle();
      if (k <= 4) begin
        exp_a = 32'h3F8 + 32'(4 * (k - 1));
        checks++;
        if (m_addr !== exp_a || m_new_trans !== (k == 1 || k == 3)
            || m_inc !== (k != 4)) begin
          errors++;
          $display("FAIL kb_beat c%0d: a %h nt %0b inc %0b want %h/%0b/%0b",
                   k, m_addr, m_new_trans, m_inc,
                   exp_a, (k == 1 || k == 3), (k != 4));
        end
      end
      checks++;
      if (done !== ((k == 5) ? 4'b0010 : 4'b0000)) begin
        errors++;
        $display("FAIL kb_done c%0d: got %b want %b",
                 k, done, (k == 5) ? 4'b0010 : 4'b0000);
      end
      tick();
    end
  endtask

  task automatic test_reset_mid();
    logic bad_done;
    set_req(2, 32'h200, 1'b0, 4'd7);
    req_valid = 4'b0100;
    settle();
    checks++;
    if (req_ready !== 4'b0100) begin
      errors++;
      $display("FAIL rm_grant: got %b want 0100", req_ready);
    end
    tick();
    req_valid = '0;
    tick();
    tick();
    settle();
    checks++;
    if (m_addr !== 32'h208) begin
      errors++;
      $display("FAIL rm_beat2: got %h want 208", m_addr);
    end
    HRESETn = 1'b0;
    tick();
    HRESETn = 1'b1;
    settle();
    checks++;
    if (busy !== 1'b0 || m_enable !== 1'b0 || m_addr !== 32'd0
        || m_new_trans !== 1'b0 || m_inc !== 1'b0) begin
      errors++;
      $display("FAIL rm_master: busy %0b en %0b a %h nt %0b inc %0b want all 0",
               busy, m_enable, m_addr, m_new_trans, m_inc);
    end
    checks++;
    if (done !== 4'd0 || rdata_valid !== 4'd0
        || wdata_ack !== 4'd0 || req_ready !== 4'd0) begin
      errors++;
      $display("FAIL rm_pulses: done %b rv %b ack %b rdy %b want 0",
               done, rdata_valid, wdata_ack, req_ready);
    end
    bad_done = 1'b0;
    for (int c = 0; c < 10; c++) begin
      settle();
      if (done != 4'd0 || busy) bad_done = 1'b1;
      tick();
    end
    checks++;
    if (bad_done) begin
      errors++;
      $display("FAIL rm_quiet: done/busy seen after reset want none");
    end
    set_req(0, 32'h0, 1'b0, 4'd3);
    set_req(2, 32'h0, 1'b0, 4'd3);
    req_valid = 4'b0101;
    settle();
    checks++;
    if (req_ready !== 4'b0001) begin
      errors++;
      $display("FAIL rm_tie: got %b want 0001", req_ready);
    end
    tick();
    req_valid = '0;
    for (int c = 0; c < 8; c++) tick();
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_single_write();
    test_round_robin();
    test_wait();
    test_boundary();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
